// File: rtl/counter_arb_pkg.sv
// ============================================================================
//  counter_arb_pkg : shared types and defaults for the counter arbiter
//  Revision 1.0
// ============================================================================
`default_nettype none

package counter_arb_pkg;

   localparam int DATA_W_DEF   = 6;
   localparam int MAX_HOLD_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN0    = 2'd1,
      OWN1    = 2'd2,
      HANDOFF = 2'd3
   } arb_state_e;

   function automatic logic [1:0] gnt_of(input arb_state_e st);
      logic [1:0] g;
      g = 2'b00;
      if (st == OWN0) g = 2'b01;
      if (st == OWN1) g = 2'b10;
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_hold_timer.sv
// ============================================================================
//  arb_hold_timer : counts consecutive grant cycles of the current owner
//  Revision 1.0
// ============================================================================
`default_nettype none

module arb_hold_timer #(
   parameter int MAX_HOLD = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // expired marks the MAX_HOLD-th consecutive grant cycle (hold reaching MAX_HOLD)
   assign expired = enable && (count_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_W'(MAX_HOLD))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/counter_arbiter.sv
// ============================================================================
//  counter_arbiter : two-client round-robin arbiter owning a shared counter.
//  Optional hold-time preemption when COUNTER_ARB_TIMEOUT_EN is defined.
//  Revision 1.0
// ============================================================================
`default_nettype none

module counter_arbiter
   import counter_arb_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        ld,
   input  logic [DATA_W-1:0] ld_data0,
   input  logic [DATA_W-1:0] ld_data1,
   output logic [1:0]        gnt,
   output logic              cnt_load,
   output logic [DATA_W-1:0] cnt_data,
   output logic              cnt_oe_n,
   output logic              timeout
);

   arb_state_e        state_q, state_d;
   logic              last_owner_q, last_owner_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              cnt_load_q, cnt_load_d;
   logic [DATA_W-1:0] cnt_data_q, cnt_data_d;
   logic              cnt_oe_n_q;
   logic              w_preempt;

`ifdef COUNTER_ARB_TIMEOUT_EN
   logic w_own;
   logic w_enter;
   logic w_expired;
   logic timeout_q;

   assign w_own   = (state_q == OWN0) || (state_q == OWN1);
   assign w_enter = ((state_d == OWN0) || (state_d == OWN1)) && (state_d != state_q);
   // Expiry only preempts when both clients want the counter; otherwise the count restarts
   assign w_preempt = w_expired && (req == 2'b11);

   arb_hold_timer #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_enter | w_expired),
      .enable  (w_own),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= w_preempt;
      end
   end

   assign timeout = timeout_q;
`else
   assign w_preempt = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE, HANDOFF: begin
            if (req == 2'b11) begin
               if (last_owner_q) begin
                  state_d      = OWN0;
                  last_owner_d = 1'b0;
               end else begin
                  state_d      = OWN1;
                  last_owner_d = 1'b1;
               end
            end else if (req[0]) begin
               state_d      = OWN0;
               last_owner_d = 1'b0;
            end else if (req[1]) begin
               state_d      = OWN1;
               last_owner_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         // A release wins over a coincident preemption, keeping timeout low
         OWN0: begin
            if (!req[0] || w_preempt) state_d = HANDOFF;
         end
         OWN1: begin
            if (!req[1] || w_preempt) state_d = HANDOFF;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d      = gnt_of(state_d);
      cnt_load_d = 1'b0;
      cnt_data_d = cnt_data_q;
      if (state_q == OWN0) begin
         cnt_load_d = ld[0];
         cnt_data_d = ld_data0;
      end else if (state_q == OWN1) begin
         cnt_load_d = ld[1];
         cnt_data_d = ld_data1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         gnt_q        <= 2'b00;
         cnt_load_q   <= 1'b0;
         cnt_data_q   <= '0;
         cnt_oe_n_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         gnt_q        <= gnt_d;
         cnt_load_q   <= cnt_load_d;
         cnt_data_q   <= cnt_data_d;
         cnt_oe_n_q   <= (gnt_d == 2'b00);
      end
   end

   assign gnt      = gnt_q;
   assign cnt_load = cnt_load_q;
   assign cnt_data = cnt_data_q;
   assign cnt_oe_n = cnt_oe_n_q;

endmodule

`default_nettype wire
